// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe: handshaked ALU stage between operand fetch and writeback.
//
// Logic, add/sub, shift and set-less-than ops finish in one cycle. Result and
// status flags (carry, signed overflow, zero, negative, illegal) are
// registered together and held until the consumer takes them.
//
// Build option:
//   ALU_MUL_EN  when defined, opcode 10 runs a WIDTH-cycle shift-add
//               multiplier (low WIDTH bits, unsigned). When undefined, the
//               multiplier is absent and opcode 10 is treated as unsupported.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake (a, b, sel)
//   a, b                  operands; shifts use b[SHW-1:0] only
//   sel                   opcode
//   out_valid / out_ready result handshake
//   out                   result
//   carry, overflow       ADD/SUB carry (no-borrow for SUB) and signed overflow
//   zero, negative        out == 0, out[WIDTH-1]
//   illegal               unsupported opcode executed
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

`ifdef ALU_MUL_EN
    localparam logic [3:0]     OP_MUL   = 4'd10;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    typedef enum logic { IDLE = 1'b0, MULT = 1'b1 } state_t;
`else
    typedef enum logic { IDLE = 1'b0 } state_t;
`endif

    state_t r_state, w_state_nxt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_carry, r_overflow, r_zero, r_negative, r_illegal;

    logic             w_accept;
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry, w_ovf, w_ill, w_is_mul;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] w_acc_nxt;

    // One shift-add step; on the last step this is the final product.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;

    // SUB reuses the adder as a + ~b + 1, so carry=1 means no borrow.
    assign w_sub     = (sel == OP_SUB);
    assign w_b_eff   = w_sub ? ~b : b;
    assign w_sum     = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    assign w_shamt   = b[SHW-1:0];

    always_comb begin
        w_res    = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        w_ill    = 1'b0;
        w_is_mul = 1'b0;
        case (sel)
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_ADD, OP_SUB: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  w_res = a << w_shamt;
            OP_SRL:  w_res = a >> w_shamt;
            OP_SRA:  w_res = $signed(a) >>> w_shamt;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MUL_EN
            OP_MUL:  w_is_mul = 1'b1;
`endif
            default: w_ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
`ifdef ALU_MUL_EN
        case (r_state)
            IDLE:    if (w_accept && w_is_mul) w_state_nxt = MULT;
            MULT:    if (r_cnt == CNT_LAST)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
`endif
    end

    // Result / flag / multiplier datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_illegal   <= 1'b0;
`ifdef ALU_MUL_EN
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            if (w_accept) begin
                if (w_is_mul) begin
`ifdef ALU_MUL_EN
                    // Old result (if any) is consumed this edge; nothing
                    // valid is presented until the product is done.
                    r_out_valid <= 1'b0;
                    r_mcand     <= a;
                    r_mplier    <= b;
                    r_acc       <= '0;
                    r_cnt       <= '0;
`endif
                end else begin
                    r_out_valid <= 1'b1;
                    r_out       <= w_res;
                    r_carry     <= w_carry;
                    r_overflow  <= w_ovf;
                    r_zero      <= (w_res == '0);
                    r_negative  <= w_res[WIDTH-1];
                    r_illegal   <= w_ill;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
`ifdef ALU_MUL_EN
            if (r_state == MULT) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    r_cnt       <= '0;
                    r_out_valid <= 1'b1;
                    r_out       <= w_acc_nxt;
                    r_carry     <= 1'b0;
                    r_overflow  <= 1'b0;
                    r_zero      <= (w_acc_nxt == '0);
                    r_negative  <= w_acc_nxt[WIDTH-1];
                    r_illegal   <= 1'b0;
                end
            end
`endif
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe: directed + randomized bench for alu_pipe (WIDTH=32).
// Expected values come from an arithmetic reference function; multiplier
// expectations follow ALU_MUL_EN the same way the design build does.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   sel = '0;
    logic         in_ready, out_valid, carry, overflow, zero, negative, illegal;
    logic [W-1:0] out;

    int checks = 0;
    int fails  = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry), .overflow(overflow),
        .zero(zero), .negative(negative), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic from the opcode definitions.
    function automatic void model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c, output logic v,
                                  output logic il, output bit is_mul);
        logic [63:0] wide;
        int          sh;
        sh = int'(y % W);
        r = '0; c = 1'b0; v = 1'b0; il = 1'b0; is_mul = 1'b0;
        case (s)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd2: r = x ^ y;
            4'd3: begin
                wide = 64'(x) + 64'(y);
                r = wide[W-1:0];
                c = wide[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'd4: begin
                r = x - y;
                c = (x >= y);
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'd5: r = x << sh;
            4'd6: r = x >> sh;
            4'd7: r = W'($signed(x) >>> sh);
            4'd8: r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'd9: r = (x < y) ? 1 : 0;
            4'd10: begin
                if (MUL_EN) begin
                    wide = 64'(x) * 64'(y);
                    r = wide[W-1:0];
                    is_mul = 1'b1;
                end else il = 1'b1;
            end
            default: il = 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        chk({tag, ".in_ready"}, in_ready, 1);
    endtask

    // Issue one operation and check result, flags and latency.
    task automatic run_op(input string tag, input logic [3:0] s, input logic [W-1:0] x,
                          input logic [W-1:0] y, output logic [W-1:0] r);
        logic c, v, il;
        bit   m;
        int   n;
        model(s, x, y, r, c, v, il, m);
        wait_ready(tag);
        in_valid = 1'b1; sel = s; a = x; b = y;
        tick();
        in_valid = 1'b0;
        // operands are latched: scramble them after acceptance
        a = $urandom; b = $urandom; sel = 4'($urandom);
        if (m) begin
            n = 0;
            while (!out_valid && n < 100) begin
                chk({tag, ".busy_in_ready"}, in_ready, 0);
                tick(); n++;
            end
            chk({tag, ".mul_latency"}, n, W);
        end else begin
            chk({tag, ".out_valid"}, out_valid, 1);
        end
        chk({tag, ".out"}, out, r);
        chk({tag, ".carry"}, carry, c);
        chk({tag, ".overflow"}, overflow, v);
        chk({tag, ".zero"}, zero, (r == '0));
        chk({tag, ".negative"}, negative, r[W-1]);
        chk({tag, ".illegal"}, illegal, il);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".out"}, out, 0);
        chk({tag, ".flags"}, {carry, overflow, zero, negative, illegal}, 0);
    endtask

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] pat [5];
        pat[0] = 32'h0; pat[1] = 32'h8000_0000; pat[2] = 32'hFFFF_FFFF;
        pat[3] = 32'h7FFF_FFFF; pat[4] = 32'h1;

        // Reset
        tick(); tick();
        rst = 1'b0;
        chk_reset_state("reset");
        chk("reset.in_ready", in_ready, 1);

        // Directed vectors, with explicit constants alongside the model
        run_op("add_ovf", 4'd3, 32'h7FFF_FFFF, 32'h1, r);
        chk("add_ovf.const", {out, overflow, carry, negative, zero}, {32'h8000_0000, 4'b1010});
        run_op("sub_neg", 4'd4, 32'd5, 32'd7, r);
        chk("sub_neg.const", {out, carry, overflow, negative}, {32'hFFFF_FFFE, 3'b001});
        run_op("sub_eq", 4'd4, 32'd7, 32'd7, r);
        chk("sub_eq.const", {out, zero, carry}, {32'h0, 2'b11});
        run_op("sra", 4'd7, 32'h8000_0000, 32'h24, r);
        chk("sra.const", out, 32'hF800_0000);
        run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'h1, r);
        chk("slt.const", out, 32'h1);
        run_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'h1, r);
        chk("sltu.const", out, 32'h0);
        run_op("mul", 4'd10, 32'h0001_0000, 32'h0001_0001, r);
        chk("mul.const", {out, illegal}, MUL_EN ? {32'h0001_0000, 1'b0} : {32'h0, 1'b1});

        // Backpressure, then same-edge consume + accept
        tick();
        out_ready = 1'b0;
        run_op("bp_add", 4'd3, 32'd1, 32'd2, r);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.hold_out", out, 32'd3);
            chk("bp.hold_valid", out_valid, 1);
            chk("bp.in_ready", in_ready, 0);
        end
        out_ready = 1'b1; in_valid = 1'b1; sel = 4'd2; a = 32'hF0; b = 32'hFF;
        #1;
        chk("bp.in_ready_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp.xor_valid", out_valid, 1);
        chk("bp.xor_out", out, 32'h0F);

        // Reset while busy (mid-multiply, or holding a stalled result)
        tick();
        wait_ready("rst_mid");
        if (MUL_EN) begin
            in_valid = 1'b1; sel = 4'd10; a = 32'h1234; b = 32'h5678;
            tick();
            in_valid = 1'b0;
            repeat (9) tick();
        end else begin
            out_ready = 1'b0;
            in_valid = 1'b1; sel = 4'd3; a = 32'hFFFF_FFFF; b = 32'h1;
            tick();
            in_valid = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        chk_reset_state("rst_mid");
        chk("rst_mid.in_ready", in_ready, 1);
        repeat (40) tick();
        chk("rst_mid.no_stale_result", out_valid, 0);
        run_op("illegal15", 4'd15, $urandom, $urandom, r);
        chk("illegal15.const", {out, zero, illegal}, {32'h0, 2'b11});

        // Randomized operations with occasional stalls
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] x, y;
            x = ($urandom_range(0, 2) == 0) ? pat[$urandom_range(0, 4)] : W'($urandom);
            y = ($urandom_range(0, 2) == 0) ? pat[$urandom_range(0, 4)] : W'($urandom);
            run_op("rand", 4'($urandom_range(0, 15)), x, y, r);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    tick();
                    chk("rand.stall_out", {out_valid, out}, {1'b1, r});
                    chk("rand.stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
